// File: rtl/scan_loader.sv
// scan_loader: streams host bytes into a serial scan chain, MSB first, and
// optionally streams the chain's previous contents back out as bytes.
// Optional feature macro: SCAN_READBACK_EN builds the capture byte, the EMIT
// state and the out_* stream. When it is undefined, out_valid/out_data are
// tied low and each byte goes straight from SHIFT to the counter step.
module scan_loader #(
  parameter int CHAIN_LEN  = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  scan_enable,
  output logic                  scan_in,
  input  logic                  scan_out
);

  localparam int NUM_BYTES = CHAIN_LEN / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] FINISH = 3'd4;
`ifdef SCAN_READBACK_EN
  localparam logic [2:0] EMIT   = 3'd3;
`endif

  logic [2:0]            state;
  logic [CNT_W-1:0]      byte_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_byte;
`ifdef SCAN_READBACK_EN
  logic [DATA_WIDTH-1:0] capture;
`endif

  // Transfer sequencer: one LOAD/SHIFT(/EMIT) round per chain byte, then FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      shift_byte <= '0;
`ifdef SCAN_READBACK_EN
      capture    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            byte_cnt <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            shift_byte <= in_data;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          shift_byte <= {shift_byte[DATA_WIDTH-2:0], 1'b0};
          bit_cnt    <= bit_cnt + 3'd1;
`ifdef SCAN_READBACK_EN
          capture    <= {capture[DATA_WIDTH-2:0], scan_out};
`endif
          if (bit_cnt == 3'd7) begin
`ifdef SCAN_READBACK_EN
            state <= EMIT;
`else
            byte_cnt <= byte_cnt + CNT_W'(1);
            state    <= (byte_cnt == LAST_BYTE) ? FINISH : LOAD;
`endif
          end
        end
`ifdef SCAN_READBACK_EN
        EMIT: begin
          if (out_ready) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            state    <= (byte_cnt == LAST_BYTE) ? FINISH : LOAD;
          end
        end
`endif
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and chain controls come from the registered state only, so no
  // input can reach them combinationally.
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);
  assign in_ready    = (state == LOAD);
  assign scan_enable = (state == SHIFT);
  assign scan_in     = scan_enable & shift_byte[DATA_WIDTH-1];

`ifdef SCAN_READBACK_EN
  assign out_valid = (state == EMIT);
  assign out_data  = capture;
`else
  logic unused_readback;
  assign out_valid       = 1'b0;
  assign out_data        = '0;
  assign unused_readback = &{1'b0, out_ready, scan_out};
`endif

endmodule

// File: tb/tb_scan_loader.sv
// tb_scan_loader: directed bench for scan_loader with a scoreboard.
// Two instances are built: a 16-bit chain (A) and the default 256-bit chain (B).
// Expected done cycles and readback bytes are queued when stimulus is issued and
// popped by a separate monitor when the DUT presents them.
module tb_scan_loader;

  localparam int LEN_A = 16;
  localparam int LEN_B = 256;
`ifdef SCAN_READBACK_EN
  localparam int PER_BYTE = 10;
  localparam bit RB       = 1'b1;
`else
  localparam int PER_BYTE = 9;
  localparam bit RB       = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;

  logic a_busy, a_done, a_in_ready, a_out_valid, a_scan_enable, a_scan_in, a_scan_out;
  logic b_busy, b_done, b_in_ready, b_out_valid, b_scan_enable, b_scan_in, b_scan_out;
  logic [7:0] a_out_data, b_out_data;
  logic a_start, b_start;

  logic [LEN_A-1:0] chain_a = '0;
  logic [LEN_B-1:0] chain_b = '0;
  logic preload_a = 1'b0;
  logic preload_b = 1'b0;
  logic [LEN_A-1:0] preload_val_a = '0;

  logic m_busy, m_done, m_in_ready, m_out_valid, m_scan_enable;
  logic [7:0] m_out_data;
  logic [13:0] outs_a, outs_b;

  int cyc = 0;
  int en_cnt = 0;
  int total = 0;
  int bad = 0;
  int exp_done[$];
  logic [7:0] exp_out[$];
  bit saw_out_valid = 1'b0;

  always #5 clk = ~clk;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  scan_loader #(.CHAIN_LEN(LEN_A), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .scan_enable(a_scan_enable), .scan_in(a_scan_in), .scan_out(a_scan_out)
  );

  scan_loader dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .scan_enable(b_scan_enable), .scan_in(b_scan_in), .scan_out(b_scan_out)
  );

  assign a_scan_out = chain_a[LEN_A-1];
  assign b_scan_out = chain_b[LEN_B-1];

  assign m_busy        = sel ? b_busy        : a_busy;
  assign m_done        = sel ? b_done        : a_done;
  assign m_in_ready    = sel ? b_in_ready    : a_in_ready;
  assign m_out_valid   = sel ? b_out_valid   : a_out_valid;
  assign m_scan_enable = sel ? b_scan_enable : a_scan_enable;
  assign m_out_data    = sel ? b_out_data    : a_out_data;

  assign outs_a = {a_busy, a_done, a_in_ready, a_out_valid, a_out_data, a_scan_enable, a_scan_in};
  assign outs_b = {b_busy, b_done, b_in_ready, b_out_valid, b_out_data, b_scan_enable, b_scan_in};

  // Chain models: shift toward the tail on each enabled edge, or take a preload.
  always @(posedge clk) begin
    if (preload_a) chain_a <= preload_val_a;
    else if (a_scan_enable) chain_a <= {chain_a[LEN_A-2:0], a_scan_in};
    if (preload_b) chain_b <= '0;
    else if (b_scan_enable) chain_b <= {chain_b[LEN_B-2:0], b_scan_in};
  end

  // Cycle counter and count of enabled shift edges on the selected instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_scan_enable) en_cnt <= en_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a readback byte or done pulse appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_out_valid) saw_out_valid = 1'b1;
      if (m_out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL out_extra: got byte %0h, wanted none", m_out_data);
        end else begin
          checkOutput("out_byte", 32'(m_out_data), 32'(exp_out.pop_front()));
        end
      end
      if (m_done) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL done_extra: got done at cycle %0d, wanted none", cyc);
        end else begin
          checkOutput("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic preloadA(input logic [LEN_A-1:0] val);
    preload_val_a = val;
    preload_a = 1'b1;
    @(negedge clk);
    preload_a = 1'b0;
  endtask

  task automatic preloadB();
    preload_b = 1'b1;
    @(negedge clk);
    preload_b = 1'b0;
  endtask

  // Entered at a negedge; pulses start for one edge and queues its done cycle.
  task automatic startXfer(input int lat, input bit accept);
    start = 1'b1;
    if (accept) exp_done.push_back(cyc + lat);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one host byte after holding in_valid low for 'stall' LOAD cycles.
  task automatic applyStimulus(input logic [7:0] d, input int stall);
    int n = 0;
    while (!m_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_reached", 32'(m_in_ready), 32'd1);
    for (int s = 0; s < stall; s++) begin
      checkOutput("load_hold_se", 32'(m_scan_enable), 32'd0);
      @(negedge clk);
    end
    in_data = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef SCAN_READBACK_EN
  // Withholds out_ready for 'stall' EMIT edges while watching the held byte.
  task automatic holdOut(input int stall, input logic [7:0] exp);
    int n = 0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    while (!m_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("emit_reached", 32'(m_out_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      checkOutput("emit_se_low", 32'(m_scan_enable), 32'd0);
      checkOutput("emit_data_hold", 32'(m_out_data), 32'(exp));
      @(posedge clk);
      if (s < stall - 1) @(negedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
  endtask
`endif

  task automatic waitIdle();
    int n = 0;
    while (m_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(m_busy), 32'd0);
    #2;
  endtask

  // Chain A preloaded 0xA5 (tail) / 0x3C, host sends 0x12 then 0x34.
  task automatic runA(input int stall_in, input int stall_out);
    int e0;
    sel = 1'b0;
    preloadA(16'hA53C);
    e0 = en_cnt;
    saw_out_valid = 1'b0;
`ifdef SCAN_READBACK_EN
    exp_out.push_back(8'hA5);
    exp_out.push_back(8'h3C);
`endif
    startXfer(PER_BYTE * 2 + 1 + stall_in + (RB ? stall_out : 0), 1'b1);
    applyStimulus(8'h12, stall_in);
`ifdef SCAN_READBACK_EN
    if (stall_out > 0) holdOut(stall_out, 8'hA5);
`endif
    applyStimulus(8'h34, 0);
    waitIdle();
    checkOutput("chain_a_contents", 32'(chain_a), 32'h1234);
    checkOutput("a_enable_cycles", 32'(en_cnt - e0), 32'd16);
    checkOutput("done_queue_empty", 32'(exp_done.size()), 32'd0);
    checkOutput("out_queue_empty", 32'(exp_out.size()), 32'd0);
`ifndef SCAN_READBACK_EN
    checkOutput("out_valid_tied", 32'(saw_out_valid), 32'd0);
`endif
  endtask

  initial begin
    int e0;
    // Reset, then idle with no start.
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({outs_a, outs_b}), 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", 32'({outs_a, outs_b}), 32'd0);
    end

    // Basic transfer, then the same with host and readback backpressure.
    runA(0, 0);
    runA(5, 7);

    // Abort in SHIFT after three bits.
    sel = 1'b0;
    preloadA(16'hA53C);
    e0 = en_cnt;
    startXfer(PER_BYTE * 2 + 1, 1'b1);
    applyStimulus(8'h55, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_pre_se", 32'(a_scan_enable), 32'd1);
    checkOutput("abort_bits", 32'(en_cnt - e0), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_se_async", 32'(a_scan_enable), 32'd0);
    checkOutput("abort_busy", 32'(a_busy), 32'd0);
    checkOutput("abort_outputs", 32'(outs_a), 32'd0);
    checkOutput("abort_no_done", 32'(exp_done.size()), 32'd1);
    exp_done.delete();
    exp_out.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_stays_idle", 32'(outs_a), 32'd0);
    runA(0, 0);

    // start pulsed mid-transfer must be ignored.
    sel = 1'b0;
    preloadA(16'hA53C);
`ifdef SCAN_READBACK_EN
    exp_out.push_back(8'hA5);
    exp_out.push_back(8'h3C);
`endif
    startXfer(PER_BYTE * 2 + 1, 1'b1);
    applyStimulus(8'h12, 0);
    startXfer(0, 1'b0);
    applyStimulus(8'h34, 0);
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("busy_start_ignored", 32'(m_busy), 32'd0);
    checkOutput("busy_chain_a", 32'(chain_a), 32'h1234);

    // Default-length chain: load byte k = k, then read it back.
    sel = 1'b1;
    preloadB();
    saw_out_valid = 1'b0;
`ifdef SCAN_READBACK_EN
    for (int k = 0; k < 32; k++) exp_out.push_back(8'h00);
`endif
    e0 = en_cnt;
    startXfer(PER_BYTE * 32 + 1, 1'b1);
    for (int k = 0; k < 32; k++) applyStimulus(8'(k), 0);
    waitIdle();
    checkOutput("b_enable_cycles", 32'(en_cnt - e0), 32'd256);
    for (int k = 0; k < 32; k++)
      checkOutput("b_chain_byte", 32'(chain_b[LEN_B-1-8*k -: 8]), 32'(k));
`ifdef SCAN_READBACK_EN
    for (int k = 0; k < 32; k++) exp_out.push_back(8'(k));
`endif
    e0 = en_cnt;
    startXfer(PER_BYTE * 32 + 1, 1'b1);
    for (int k = 0; k < 32; k++) applyStimulus(8'hC0, 0);
    waitIdle();
    checkOutput("b_enable_cycles_2", 32'(en_cnt - e0), 32'd256);
    checkOutput("b_tail_byte_2", 32'(chain_b[LEN_B-1 -: 8]), 32'hC0);
    checkOutput("b_done_queue", 32'(exp_done.size()), 32'd0);
    checkOutput("b_out_queue", 32'(exp_out.size()), 32'd0);
`ifndef SCAN_READBACK_EN
    checkOutput("b_out_valid_tied", 32'(saw_out_valid), 32'd0);
    checkOutput("b_out_data_tied", 32'(b_out_data), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
